// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, sample type and pooling FSM state
package conv_pkg;

    localparam int CONV_IN_DIM  = 8;
    localparam int CONV_K       = 3;
    localparam int CONV_OUT_DIM = 6;
    localparam int CONV_DATA_W  = 16;

    typedef logic [15:0] conv_sample_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } pool_state_e;

endpackage

// File: rtl/max2.sv
// rtl/max2.sv - combinational two-input maximum, signed or unsigned compare
module max2 #(
    parameter int DATA_W     = 16,
    parameter int SIGNED_CMP = 0
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] max_o
);

    logic a_ge_b;

    always_comb begin
        if (SIGNED_CMP != 0) begin
            a_ge_b = $signed(a_i) >= $signed(b_i);
        end else begin
            a_ge_b = a_i >= b_i;
        end
        max_o = a_ge_b ? a_i : b_i;
    end

endmodule

// File: rtl/conv_maxpool.sv
// rtl/conv_maxpool.sv - 2x2 stride-2 max pooling of the conv result stream
module conv_maxpool
    import conv_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IN_DIM     = 6,
    parameter int SIGNED_CMP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_out_st,
    input  logic [DATA_W-1:0] conv_dout,
    output logic [DATA_W-1:0] pool_dout,
    output logic              pool_valid,
    output logic              pool_first,
    output logic              pool_done,
    output logic              busy
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW      = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
    localparam int JW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_DIM - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    pool_state_e       state_q, state_d;
    logic [CW-1:0]     row_q, col_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rowbuf_q [OUT_DIM];
    logic [DATA_W-1:0] dout_q;
    logic              valid_q, first_q, done_q;
    logic              accept, last_sample, win_end;
    logic [JW-1:0]     j;
    logic [DATA_W-1:0] upd_a, upd_max, out_max;

    assign j = JW'(col_q >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (conv_out_st) state_d = COLLECT;
            COLLECT: if (last_sample) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept      = (state_q == COLLECT);
        busy        = accept;
        last_sample = accept && (row_q == LAST) && (col_q == LAST);
        win_end     = accept && row_q[0] && col_q[0];
    end

    // Even rows fold into rowbuf/hold; odd rows fold rowbuf back in, then emit.
    assign upd_a = row_q[0] ? rowbuf_q[j] : hold_q;

    max2 #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_max_row (
        .a_i  (upd_a),
        .b_i  (conv_dout),
        .max_o(upd_max)
    );

    max2 #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_max_out (
        .a_i  (hold_q),
        .b_i  (conv_dout),
        .max_o(out_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (!accept) begin
            if (conv_out_st) begin
                row_q <= '0;
                col_q <= '0;
            end
        end else if (col_q == LAST) begin
            col_q <= '0;
            row_q <= last_sample ? '0 : row_q + ONE;
        end else begin
            col_q <= col_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            dout_q <= '0;
            for (int i = 0; i < OUT_DIM; i++) rowbuf_q[i] <= '0;
        end else if (accept) begin
            case ({row_q[0], col_q[0]})
                2'b00:   hold_q      <= conv_dout;
                2'b01:   rowbuf_q[j] <= upd_max;
                2'b10:   hold_q      <= upd_max;
                default: dout_q      <= out_max;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= win_end;
            first_q <= win_end && (row_q == ONE) && (col_q == ONE);
            done_q  <= win_end && last_sample;
        end
    end

    assign pool_dout  = dout_q;
    assign pool_valid = valid_q;
    assign pool_first = first_q;
    assign pool_done  = done_q;

endmodule

// File: doc/conv_maxpool.md
Name: conv_maxpool

Overview:
- Downstream stage of Conv: consumes the 6x6 16-bit convolution result stream (Conv `dout`/`out_st`) and performs 2x2, stride-2 max pooling.
- Emits a 3x3 pooled map in raster order with a valid strobe and frame start/done pulses.
- Needs only a one-row partial-max buffer, no frame buffer.
- Sits between Conv and the result capture/readout logic.

Parameters:
- DATA_W, 16, width of conv samples and pooled outputs.
- IN_DIM, 6, conv output side length; must be even and at least 2.
- OUT_DIM, IN_DIM/2, pooled side length; localparam, not overridable.
- SIGNED_CMP, 0, 1 = compare samples as two's complement, 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock, shared with Conv.
- rst  in  1  asynchronous active-high reset.
- conv_out_st  in  1  one-cycle pulse from Conv; results start the next cycle.
- conv_dout  in  DATA_W  conv result, raster order, one per cycle for IN_DIM*IN_DIM cycles after conv_out_st.
- pool_dout  out  DATA_W  pooled value, valid when pool_valid=1.
- pool_valid  out  1  one-cycle strobe per pooled value.
- pool_first  out  1  high with pool_valid on output (0,0).
- pool_done  out  1  high with pool_valid on the last output (OUT_DIM-1,OUT_DIM-1).
- busy  out  1  high while a frame is being collected.

Behaviour:
- Reset (async, rst=1): state=IDLE, counters=0, row buffer=0, hold=0.
- Reset outputs: pool_dout=0, pool_valid=0, pool_first=0, pool_done=0, busy=0.
- Reset mid-frame: the partial frame is discarded; after reset, no output until the next conv_out_st.
- State machine, two states:
  - IDLE: on conv_out_st=1 go to COLLECT, clear row=0 and col=0, set busy=1 from the next edge.
  - COLLECT: one sample of conv_dout is accepted every cycle; there is no stall.
  - Leave COLLECT after the sample at row=IN_DIM-1, col=IN_DIM-1; return to IDLE and drop busy on the same edge.
- conv_out_st while in COLLECT is ignored; the frame is not restarted.
- Sample handling per (row, col), j = col/2:
  - even row, even col: hold <= x.
  - even row, odd col: rowbuf[j] <= max(hold, x).
  - odd row, even col: hold <= max(rowbuf[j], x).
  - odd row, odd col: pool_dout <= max(hold, x); pool_valid <= 1.
- Counters: col wraps IN_DIM-1 -> 0 and increments row. rowbuf has OUT_DIM entries of DATA_W.
- Latency: pool_valid is asserted the cycle after the bottom-right sample of each 2x2 window is presented.
  - Relative to conv_out_st at cycle T, sample k arrives at T+1+k.
  - The first output is at T+IN_DIM+3, i.e. T+9 for the default IN_DIM=6.
  - The last output is at T+IN_DIM*IN_DIM+1, i.e. T+37.
- pool_first and pool_done are set only together with pool_valid.
- pool_valid, pool_first and pool_done are cleared on every cycle without an output.
- pool_dout holds its last value between strobes.
- Comparison:
  - SIGNED_CMP=1: $signed compare.
  - SIGNED_CMP=0: unsigned compare.
  - Ties select either operand (values are equal).
  - No width growth; output width = DATA_W.
- Back-to-back frames: a conv_out_st arriving in the cycle right after the last sample (state already IDLE) is accepted.

Decomposition:
- Shared package conv_pkg holds:
  - constants CONV_IN_DIM=8, CONV_K=3, CONV_OUT_DIM=6, CONV_DATA_W=16;
  - typedef conv_sample_t = logic [15:0];
  - the pool state enum {IDLE, COLLECT}.
- One sub-module: max2, a combinational 2-input max parameterised by DATA_W and SIGNED_CMP, instanced twice (row-buffer path and output path).

Test Plan:
- Ascending ramp: pulse conv_out_st at T, drive conv_dout = 0..35 on T+1..T+36.
  - Expect pool_dout sequence 7,9,11,19,21,23,31,33,35.
  - pool_valid at T+9,T+11,T+13,T+21,T+23,T+25,T+33,T+35,T+37.
  - pool_first at T+9, pool_done at T+37.
- Descending ramp 35..0: expect 35,33,31,23,21,19,11,9,7 with the same timing.
- Signed compare, SIGNED_CMP=1:
  - Frame of all 16'hFFFF except window (0,0) bottom-right = 16'h0001 -> first output 16'h0001.
  - Same frame with SIGNED_CMP=0 -> first output 16'hFFFF.
- Reset mid-frame: assert rst at sample 20 -> all outputs 0 immediately and busy=0. A new frame of all 16'h0005 then yields nine outputs of 5.
- Spurious conv_out_st at sample 10 -> ignored; the 0..35 ramp still yields the ascending result set.
- Back-to-back frames: second conv_out_st at T+37 -> 18 valid outputs total, two pool_done pulses.
